top_tdr_creation_tessent_tdr_mux_ctrl: RTL



---
 rtl/top_tdr_creation_tdr_pkg.sv | 33 +++
 rtl/top_tdr_creation_tdr_shift_guard.sv | 74 +++++++
 rtl/top_tdr_creation_tessent_tdr_mux_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/top_tdr_creation_tdr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : top_tdr_creation_tdr_pkg
// Purpose  : Shared sizing helpers and bit-position constants for the IJTAG
//            mux-control TDR.
//            Scan register layout is {select, data[W-1:0], error_status}.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package top_tdr_creation_tdr_pkg;

  // Status bit sits at the LSB so it is the first bit seen on scan-out.
  localparam int ERR_POS  = 0;
  localparam int DATA_LSB = 1;

  // Total scan length: select bit + data field + status bit.
  function automatic int TDR_LEN(input int width);
    return width + 2;
  endfunction

  // The select bit sits at the MSB of the scan register.
  function automatic int SEL_POS(input int width);
    return width + 1;
  endfunction

  // The counter must be able to hold LEN+1 ("more than LEN"), so it needs
  // clog2(LEN+2) bits.
  function automatic int TDR_CNT_W(input int width);
    return $clog2(TDR_LEN(width) + 2);
  endfunction

endpackage : top_tdr_creation_tdr_pkg
`default_nettype wire

// File: rtl/top_tdr_creation_tdr_shift_guard.sv
`default_nettype none
// ============================================================================
// Module   : top_tdr_creation_tdr_shift_guard
// Purpose  : Saturating shift counter and sticky length-error flag.
//            The counter runs on the rising edge.
//            The error flag is written on the falling edge, together with
//            the update register.
// Ports    : clk_i          - ijtag_tck
//            rst_i          - async active-high reset
//            capture_i      - qualified capture (clears the counter)
//            shift_i        - qualified shift (increments, saturating)
//            update_i       - qualified update (samples the length check)
//            len_ok_o       - counter currently equals LEN
//            length_error_o - last update had an illegal shift count
// Revision : 1.0 - initial release
// ============================================================================
module top_tdr_creation_tdr_shift_guard #(
  parameter int LEN   = 5,
  parameter int CNT_W = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic capture_i,
  input  logic shift_i,
  input  logic update_i,
  output logic len_ok_o,
  output logic length_error_o
);

  // Saturate at LEN+1 so a long scan can never wrap back onto LEN.
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LEN = CNT_W'(LEN);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  always_comb begin
    cnt_d = cnt_q;
    if (capture_i) begin
      cnt_d = '0;
    end else if (shift_i && (cnt_q != CNT_SAT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign len_ok_o = (cnt_q == CNT_LEN);

  always_comb begin
    err_d = err_q;
    if (update_i) begin
      err_d = ~len_ok_o;
    end
  end

  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign length_error_o = err_q;

endmodule : top_tdr_creation_tdr_shift_guard
`default_nettype wire

// File: rtl/top_tdr_creation_tessent_tdr_mux_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : top_tdr_creation_tessent_tdr_mux_ctrl
// Purpose  : IJTAG TDR driving the select and data inputs of the downstream
//            data mux.
//            It is accessed with the usual capture/shift/update protocol.
//            An update whose shift count is not exactly LEN is rejected and
//            flagged on length_error.
// Config   : `TDR_CAPTURE_FUNC_EN - when defined, capture observes
//            functional_data_in.
//            When undefined, capture reads back ijtag_data_out.
// Ports    : ijtag_tck          - clock (shift/capture posedge, update/so negedge)
//            ijtag_reset        - async active-high reset
//            ijtag_sel/ce/se/ue - network select, capture, shift, update enables
//            ijtag_si/ijtag_so  - scan in / scan out (negedge retimed)
//            functional_data_in - functional value observed at capture
//            ijtag_select       - mux select (1 = IJTAG data drives the mux)
//            ijtag_data_out     - mux ijtag_data_in
//            length_error       - sticky illegal-shift-count flag
// Revision : 1.0 - initial release
// ============================================================================
module top_tdr_creation_tessent_tdr_mux_ctrl
  import top_tdr_creation_tdr_pkg::*;
#(
  parameter int unsigned             DATA_WIDTH       = 3,
  parameter logic [DATA_WIDTH-1:0]   DATA_RESET_VALUE = '0
) (
  input  logic                  ijtag_tck,
  input  logic                  ijtag_reset,
  input  logic                  ijtag_sel,
  input  logic                  ijtag_ce,
  input  logic                  ijtag_se,
  input  logic                  ijtag_ue,
  input  logic                  ijtag_si,
  output logic                  ijtag_so,
  input  logic [DATA_WIDTH-1:0] functional_data_in,
  output logic                  ijtag_select,
  output logic [DATA_WIDTH-1:0] ijtag_data_out,
  output logic                  length_error
);

  localparam int LEN   = TDR_LEN(DATA_WIDTH);
  localparam int CNT_W = TDR_CNT_W(DATA_WIDTH);
  localparam int SPOS  = SEL_POS(DATA_WIDTH);
  localparam int DMSB  = DATA_LSB + DATA_WIDTH - 1;

  logic [LEN-1:0]        sr_q, sr_d;
  logic                  so_q;
  logic                  select_q, select_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] cap_data;
  logic                  capture, shift, update, len_ok;

  // Capture has priority over shift when both enables are high.
  assign capture = ijtag_sel & ijtag_ce;
  assign shift   = ijtag_sel & ijtag_se & ~ijtag_ce;
  assign update  = ijtag_sel & ijtag_ue;

`ifdef TDR_CAPTURE_FUNC_EN
  assign cap_data = functional_data_in;
`else
  // Readback of the update register; the functional port is kept for a
  // stable interface but has no load here.
  logic unused_functional;
  assign unused_functional = ^functional_data_in;
  assign cap_data          = data_q;
`endif

  always_comb begin
    sr_d = sr_q;
    if (capture) begin
      sr_d[SPOS]          = select_q;
      sr_d[DMSB:DATA_LSB] = cap_data;
      sr_d[ERR_POS]       = length_error;
    end else if (shift) begin
      sr_d = {ijtag_si, sr_q[LEN-1:1]};
    end
  end

  always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  top_tdr_creation_tdr_shift_guard #(
    .LEN   (LEN),
    .CNT_W (CNT_W)
  ) u_shift_guard (
    .clk_i          (ijtag_tck),
    .rst_i          (ijtag_reset),
    .capture_i      (capture),
    .shift_i        (shift),
    .update_i       (update),
    .len_ok_o       (len_ok),
    .length_error_o (length_error)
  );

  // The status bit in sr is never transferred; only select and data update.
  always_comb begin
    select_d = select_q;
    data_d   = data_q;
    if (update && len_ok) begin
      select_d = sr_q[SPOS];
      data_d   = sr_q[DMSB:DATA_LSB];
    end
  end

  // Falling-edge update and lockup retime of scan-out.
  always_ff @(negedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      so_q     <= 1'b0;
      select_q <= 1'b0;
      data_q   <= DATA_RESET_VALUE;
    end else begin
      so_q     <= sr_q[ERR_POS];
      select_q <= select_d;
      data_q   <= data_d;
    end
  end

  assign ijtag_so       = so_q;
  assign ijtag_select   = select_q;
  assign ijtag_data_out = data_q;

endmodule : top_tdr_creation_tessent_tdr_mux_ctrl
`default_nettype wire
